// File: rtl/avmm_host_arbiter.sv
// avmm_host_arbiter
// Two Avalon-MM masters (m0, m1) share one host master port (h_*).
// Commands are arbitrated combinationally and forwarded in the same cycle.
// Write bursts lock the grant until their last beat. Read bursts are tracked
// in a pending FIFO of {id, length}, which routes read responses back to the
// master that issued them.
// Optional build macro: AVMM_ARB_FIXED_PRIO_EN. When it is defined, m0 always
// wins simultaneous requests. When it is undefined, round robin is used.
module avmm_host_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int BURST_W    = 5,
  parameter int PEND_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  // master 0
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [BURST_W-1:0]  m0_burstcount,
  input  logic [DATA_W-1:0]   m0_writedata,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  // master 1
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [BURST_W-1:0]  m1_burstcount,
  input  logic [DATA_W-1:0]   m1_writedata,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  // host port
  output logic [ADDR_W-1:0]   h_address,
  output logic                h_read,
  output logic                h_write,
  output logic [BURST_W-1:0]  h_burstcount,
  output logic [DATA_W-1:0]   h_writedata,
  output logic [DATA_W/8-1:0] h_byteenable,
  input  logic                h_waitrequest,
  input  logic [DATA_W-1:0]   h_readdata,
  input  logic                h_readdatavalid,
  // sticky error: read data arrived with nothing outstanding
  output logic                err_unexp_rdv
);

  localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
  localparam int CNT_W = $clog2(PEND_DEPTH + 1);

  typedef enum logic [0:0] {IDLE = 1'b0, WR_BURST = 1'b1} state_t;

  state_t             state_q, state_d;
  logic               last_q, last_d;       // id of the last accepted grant
  logic               lock_q, lock_d;       // master owning the write burst
  logic [BURST_W-1:0] wr_left_q, wr_left_d; // write beats still to come
  logic [BURST_W-1:0] beat_q, beat_d;       // beats returned for head burst
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic               err_q, err_d;

  logic               fifo_id_q  [PEND_DEPTH];
  logic [BURST_W-1:0] fifo_len_q [PEND_DEPTH];

  logic               fifo_full_s, fifo_empty_s;
  logic               elig0_s, elig1_s;
  logic               gnt_vld_s, gnt_id_s;
  logic               sel_rd_s, sel_wr_s;
  logic               fwd_s, push_s, pop_s, rdv_hit_s, last_beat_s;
  logic               head_id_s;
  logic [BURST_W-1:0] head_len_s, push_len_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(PEND_DEPTH - 1)) begin
      ptr_inc = '0;
    end else begin
      ptr_inc = p + PTR_W'(1);
    end
  endfunction

  assign fifo_full_s  = (cnt_q == CNT_W'(PEND_DEPTH));
  assign fifo_empty_s = (cnt_q == CNT_W'(0));
  // reads cannot be taken while the pending FIFO is full; writes still can
  assign elig0_s = m0_write | (m0_read & ~fifo_full_s);
  assign elig1_s = m1_write | (m1_read & ~fifo_full_s);

  // Grant selection: the locked master during a write burst, otherwise arbitrate.
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_id_s  = 1'b0;
    if (state_q == WR_BURST) begin
      gnt_vld_s = 1'b1;
      gnt_id_s  = lock_q;
    end else if (elig0_s && elig1_s) begin
      gnt_vld_s = 1'b1;
`ifdef AVMM_ARB_FIXED_PRIO_EN
      gnt_id_s  = 1'b0;
`else
      gnt_id_s  = ~last_q;
`endif
    end else if (elig0_s) begin
      gnt_vld_s = 1'b1;
      gnt_id_s  = 1'b0;
    end else if (elig1_s) begin
      gnt_vld_s = 1'b1;
      gnt_id_s  = 1'b1;
    end else begin
      gnt_vld_s = 1'b0;
      gnt_id_s  = 1'b0;
    end
  end

  // Forward the granted master's command fields to the host port.
  always_comb begin
    if (gnt_id_s) begin
      sel_rd_s      = m1_read;
      sel_wr_s      = m1_write;
      h_address     = m1_address;
      h_burstcount  = m1_burstcount;
      h_writedata   = m1_writedata;
      h_byteenable  = m1_byteenable;
    end else begin
      sel_rd_s      = m0_read;
      sel_wr_s      = m0_write;
      h_address     = m0_address;
      h_burstcount  = m0_burstcount;
      h_writedata   = m0_writedata;
      h_byteenable  = m0_byteenable;
    end
  end

  // Command strobes. A locked write burst forwards writes only. Reset blocks all.
  always_comb begin
    h_write = 1'b0;
    h_read  = 1'b0;
    if (!reset && gnt_vld_s) begin
      h_write = sel_wr_s;
      h_read  = (state_q == IDLE) && sel_rd_s && !sel_wr_s;
    end else begin
      h_write = 1'b0;
      h_read  = 1'b0;
    end
  end

  assign fwd_s          = h_read | h_write;
  assign m0_waitrequest = ~(fwd_s & ~gnt_id_s) | h_waitrequest;
  assign m1_waitrequest = ~(fwd_s &  gnt_id_s) | h_waitrequest;

  // read response routing: data broadcast, valid steered by the FIFO head
  assign head_id_s        = fifo_id_q[rd_ptr_q];
  assign head_len_s       = fifo_len_q[rd_ptr_q];
  assign rdv_hit_s        = h_readdatavalid & ~fifo_empty_s & ~reset;
  assign last_beat_s      = (beat_q == (head_len_s - BURST_W'(1)));
  assign m0_readdata      = h_readdata;
  assign m1_readdata      = h_readdata;
  assign m0_readdatavalid = rdv_hit_s & ~head_id_s;
  assign m1_readdatavalid = rdv_hit_s &  head_id_s;
  assign err_unexp_rdv    = err_q;

  assign push_s     = h_read & ~h_waitrequest;
  assign pop_s      = rdv_hit_s & last_beat_s;
  assign push_len_s = (h_burstcount == BURST_W'(0)) ? BURST_W'(1) : h_burstcount;

  // Next state: write-burst lock, RR pointer, pending FIFO bookkeeping, error flag.
  always_comb begin
    state_d   = state_q;
    lock_d    = lock_q;
    wr_left_d = wr_left_q;
    last_d    = last_q;
    if (fwd_s && !h_waitrequest) begin
      last_d = gnt_id_s;
    end else begin
      last_d = last_q;
    end
    case (state_q)
      IDLE: begin
        if (h_write && !h_waitrequest && (h_burstcount > BURST_W'(1))) begin
          state_d   = WR_BURST;
          lock_d    = gnt_id_s;
          wr_left_d = h_burstcount - BURST_W'(1);
        end else begin
          state_d   = IDLE;
        end
      end
      WR_BURST: begin
        if (h_write && !h_waitrequest) begin
          wr_left_d = wr_left_q - BURST_W'(1);
          if (wr_left_q == BURST_W'(1)) begin
            state_d = IDLE;
          end else begin
            state_d = WR_BURST;
          end
        end else begin
          state_d = WR_BURST;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_ptr_d = push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    if (rdv_hit_s) begin
      beat_d = last_beat_s ? BURST_W'(0) : (beat_q + BURST_W'(1));
    end else begin
      beat_d = beat_q;
    end
    err_d = err_q | (h_readdatavalid & fifo_empty_s & ~reset);
  end

  // State registers; reset abandons every pending burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      lock_q    <= 1'b0;
      wr_left_q <= '0;
      beat_q    <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      lock_q    <= lock_d;
      wr_left_q <= wr_left_d;
      beat_q    <= beat_d;
      cnt_q     <= cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      err_q     <= err_d;
    end
  end

  // Pending FIFO storage; validity comes from the counters above.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_id_q[wr_ptr_q]  <= gnt_id_s;
      fifo_len_q[wr_ptr_q] <= push_len_s;
    end
  end

endmodule

// File: tb/tb_avmm_host_arbiter.sv
// Self-checking bench for avmm_host_arbiter: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based reference model.
module tb_avmm_host_arbiter;
  localparam int AW = 64, DW = 512, BW = 5, DEPTH = 16, BEW = DW / 8;
`ifdef AVMM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0]  m_addr [2];
  logic           m_rd   [2];
  logic           m_wr   [2];
  logic [BW-1:0]  m_bc   [2];
  logic [DW-1:0]  m_wd   [2];
  logic [BEW-1:0] m_be   [2];
  logic           m_wait [2];
  logic [DW-1:0]  m_rdat [2];
  logic           m_rdv  [2];
  logic [AW-1:0]  h_address;
  logic           h_read, h_write, h_wait, h_rdv, err;
  logic [BW-1:0]  h_burstcount;
  logic [DW-1:0]  h_writedata, h_rdata;
  logic [BEW-1:0] h_byteenable;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b1;

  // reference model state
  int m_last, m_lock, m_left, m_served;
  bit m_err;
  int q_id[$];
  int q_len[$];

  avmm_host_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_address(m_addr[0]), .m0_read(m_rd[0]), .m0_write(m_wr[0]),
    .m0_burstcount(m_bc[0]), .m0_writedata(m_wd[0]), .m0_byteenable(m_be[0]),
    .m0_waitrequest(m_wait[0]), .m0_readdata(m_rdat[0]), .m0_readdatavalid(m_rdv[0]),
    .m1_address(m_addr[1]), .m1_read(m_rd[1]), .m1_write(m_wr[1]),
    .m1_burstcount(m_bc[1]), .m1_writedata(m_wd[1]), .m1_byteenable(m_be[1]),
    .m1_waitrequest(m_wait[1]), .m1_readdata(m_rdat[1]), .m1_readdatavalid(m_rdv[1]),
    .h_address(h_address), .h_read(h_read), .h_write(h_write),
    .h_burstcount(h_burstcount), .h_writedata(h_writedata), .h_byteenable(h_byteenable),
    .h_waitrequest(h_wait), .h_readdata(h_rdata), .h_readdatavalid(h_rdv),
    .err_unexp_rdv(err)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endfunction

  // Compare process: derive expected outputs from the model, check, then advance the model.
  always @(negedge clk) begin : cmp
    int g, gi, len;
    bit full, can0, can1, fw_w, fw_r, acc;
    if (chk_en) begin
      if (reset) begin
        chk("rst_h_read", h_read, 1'b0);
        chk("rst_h_write", h_write, 1'b0);
        chk("rst_m0_wait", m_wait[0], 1'b1);
        chk("rst_m1_wait", m_wait[1], 1'b1);
        chk("rst_m0_rdv", m_rdv[0], 1'b0);
        chk("rst_m1_rdv", m_rdv[1], 1'b0);
        chk("rst_err", err, 1'b0);
        m_last = 1; m_lock = -1; m_left = 0; m_served = 0; m_err = 1'b0;
        q_id.delete(); q_len.delete();
      end else begin
        full = (q_id.size() >= DEPTH);
        can0 = m_wr[0] || (m_rd[0] && !full);
        can1 = m_wr[1] || (m_rd[1] && !full);
        g = -1;
        if (m_lock >= 0) g = m_lock;
        else if (can0 && can1) g = FIXED ? 0 : ((m_last == 0) ? 1 : 0);
        else if (can0) g = 0;
        else if (can1) g = 1;
        gi = (g < 0) ? 0 : g;
        fw_w = (g >= 0) && m_wr[gi];
        fw_r = (g >= 0) && (m_lock < 0) && m_rd[gi] && !m_wr[gi];
        chk("h_write", h_write, fw_w);
        chk("h_read", h_read, fw_r);
        chk("m0_wait", m_wait[0], !((g == 0) && (fw_w || fw_r)) || h_wait);
        chk("m1_wait", m_wait[1], !((g == 1) && (fw_w || fw_r)) || h_wait);
        if (fw_w || fw_r) begin
          chk("h_address", h_address, m_addr[gi]);
          chk("h_burstcount", h_burstcount, m_bc[gi]);
        end
        if (fw_w) begin
          chk("h_writedata", h_writedata, m_wd[gi]);
          chk("h_byteenable", h_byteenable, m_be[gi]);
        end
        chk("m0_rdv", m_rdv[0], h_rdv && (q_id.size() > 0) && (q_id[0] == 0));
        chk("m1_rdv", m_rdv[1], h_rdv && (q_id.size() > 0) && (q_id[0] == 1));
        chk("m0_rdata", m_rdat[0], h_rdata);
        chk("m1_rdata", m_rdat[1], h_rdata);
        chk("err", err, m_err);
        // advance model
        if (h_rdv) begin
          if (q_id.size() == 0) m_err = 1'b1;
          else begin
            m_served++;
            if (m_served == q_len[0]) begin
              void'(q_id.pop_front()); void'(q_len.pop_front()); m_served = 0;
            end
          end
        end
        acc = (fw_w || fw_r) && !h_wait;
        if (acc) begin
          len = (m_bc[gi] == 0) ? 1 : int'(m_bc[gi]);
          m_last = g;
          if (fw_r) begin
            q_id.push_back(g); q_len.push_back(len);
          end else if (m_lock < 0) begin
            if (len > 1) begin m_lock = g; m_left = len - 1; end
          end else begin
            m_left--;
            if (m_left == 0) m_lock = -1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    for (int n = 0; n < 2; n++) begin
      m_addr[n] = '0; m_rd[n] = 1'b0; m_wr[n] = 1'b0; m_bc[n] = '0;
      m_wd[n] = '0; m_be[n] = '0;
    end
    h_wait = 1'b0; h_rdv = 1'b0; h_rdata = '0;
  endtask

  initial begin
    int pct;
    reset = 1'b1;
    clr();
    repeat (3) step();
    #3 chk("lit_rst_h_read", h_read, 1'b0);
    chk("lit_rst_m0_wait", m_wait[0], 1'b1);
    step();
    reset = 1'b0;

    // two reads in the same cycle: m0 first, then m1; responses routed in order
    m_rd[0] = 1'b1; m_bc[0] = 5'd4; m_addr[0] = 64'h1000;
    m_rd[1] = 1'b1; m_bc[1] = 5'd2; m_addr[1] = 64'h2000;
    #3 chk("a_first_addr", h_address, 64'h1000);
    chk("a_m1_wait", m_wait[1], 1'b1);
    step();
    m_rd[0] = 1'b0;
    #3 chk("a_second_addr", h_address, 64'h2000);
    chk("a_second_bc", h_burstcount, 5'd2);
    step();
    m_rd[1] = 1'b0;
    for (int i = 0; i < 6; i++) begin
      h_rdv = 1'b1; h_rdata = {16{$urandom}};
      #3 chk("a_rdv_m0", m_rdv[0], (i < 4));
      chk("a_rdv_m1", m_rdv[1], (i >= 4));
      step();
    end
    h_rdv = 1'b0;

    // write burst of 8 locks out a concurrent m1 read
    m_wr[0] = 1'b1; m_bc[0] = 5'd8; m_addr[0] = 64'h3000; m_wd[0] = {16{$urandom}};
    m_rd[1] = 1'b1; m_bc[1] = 5'd1; m_addr[1] = 64'h4000;
    for (int i = 0; i < 8; i++) begin
      #3 chk("b_h_write", h_write, 1'b1);
      chk("b_m1_wait", m_wait[1], 1'b1);
      step();
    end
    m_wr[0] = 1'b0;
    #3 chk("b_m1_read_issued", h_read, 1'b1);
    chk("b_m1_addr", h_address, 64'h4000);
    step();
    m_rd[1] = 1'b0; h_rdv = 1'b1;
    #3 chk("b_m1_rdv", m_rdv[1], 1'b1);
    step();
    h_rdv = 1'b0;

    // fill the pending FIFO, 17th read stalls, write still passes
    m_addr[0] = 64'h5000; m_bc[0] = 5'd1;
    for (int i = 0; i < 16; i++) begin
      m_rd[0] = 1'b1;
      #3 chk("c_fill_wait", m_wait[0], 1'b0);
      step();
    end
    m_wr[1] = 1'b1; m_bc[1] = 5'd1; m_addr[1] = 64'h6000;
    #3 chk("c_17th_stalled", m_wait[0], 1'b1);
    chk("c_write_served", h_write, 1'b1);
    chk("c_write_addr", h_address, 64'h6000);
    step();
    m_wr[1] = 1'b0; h_rdv = 1'b1;
    #3 chk("c_still_stalled", m_wait[0], 1'b1);
    chk("c_rdv_m0", m_rdv[0], 1'b1);
    step();
    h_rdv = 1'b0;
    #3 chk("c_unblocked", h_read, 1'b1);
    chk("c_unblocked_wait", m_wait[0], 1'b0);
    step();
    m_rd[0] = 1'b0; h_rdv = 1'b1;
    repeat (16) step();
    h_rdv = 1'b0;

    // unexpected read data with nothing pending
    h_rdv = 1'b1;
    #3 chk("d_no_rdv0", m_rdv[0], 1'b0);
    chk("d_no_rdv1", m_rdv[1], 1'b0);
    step();
    h_rdv = 1'b0;
    #3 chk("d_err_set", err, 1'b1);
    repeat (3) step();
    #3 chk("d_err_sticky", err, 1'b1);
    step();

    // reset on the 3rd beat of a write burst of 8
    m_wr[0] = 1'b1; m_bc[0] = 5'd8; m_addr[0] = 64'h7000;
    repeat (2) step();
    reset = 1'b1;
    #3 chk("f_write_dropped", h_write, 1'b0);
    chk("f_err_cleared", err, 1'b0);
    repeat (2) step();
    reset = 1'b0; m_wr[0] = 1'b0;
    m_wr[1] = 1'b1; m_bc[1] = 5'd1; m_addr[1] = 64'h8000;
    #3 chk("f_m1_write", h_write, 1'b1);
    chk("f_m1_addr", h_address, 64'h8000);
    chk("f_m1_wait", m_wait[1], 1'b0);
    step();

    // continuous requests from both: alternate (or m0 always with fixed priority)
    m_wr[0] = 1'b1; m_bc[0] = 5'd1; m_addr[0] = 64'h9000;
    m_wr[1] = 1'b1; m_bc[1] = 5'd1; m_addr[1] = 64'hA000;
    for (int i = 0; i < 4; i++) begin
      #3 chk("e_grant_addr", h_address, (FIXED || (i % 2 == 0)) ? 64'h9000 : 64'hA000);
      step();
    end
    clr();
    step();

    // randomized traffic
    pct = 40;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) pct = (c % 1500 == 0) ? 10 : ((c % 1000 == 0) ? 80 : 40);
      for (int n = 0; n < 2; n++) begin
        int op;
        op = $urandom_range(0, 9);
        m_rd[n] = (op <= 3) || (op == 7);
        m_wr[n] = (op >= 4) && (op <= 7);
        m_bc[n] = ($urandom_range(0, 15) == 0) ? 5'd16 : BW'($urandom_range(0, 6));
        m_addr[n] = {$urandom, $urandom};
        m_wd[n] = {16{$urandom}};
        m_be[n] = {$urandom, $urandom};
      end
      h_wait = ($urandom_range(0, 3) == 0);
      h_rdv = ($urandom_range(0, 99) < pct);
      h_rdata = {16{$urandom}};
      reset = ($urandom_range(0, 799) == 0);
      step();
    end
    clr();
    reset = 1'b0;
    repeat (2) step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/avmm_host_arbiter.md
AVMM_HOST_ARBITER -- requirements
Module: avmm_host_arbiter

Interface
REQ-001 The block SHALL use parameter ADDR_W, default 64, as the Avalon-MM address width.
REQ-002 The block SHALL use parameter DATA_W, default 512, as the data width; byteenable width SHALL be DATA_W/8.
REQ-003 The block SHALL use parameter BURST_W, default 5, as the burstcount width (max burst 16).
REQ-004 The block SHALL use parameter PEND_DEPTH, default 16, as the number of outstanding read bursts tracked.
REQ-005 The block SHALL have one clock and an asynchronous active-high reset:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high
REQ-006 The block SHALL have two master-side slave ports mN, N=0,1:
- mN_address  in  ADDR_W  byte address
- mN_read, mN_write  in  1  command strobes
- mN_burstcount  in  BURST_W  burst length
- mN_writedata  in  DATA_W  write data
- mN_byteenable  in  DATA_W/8  byte enables
- mN_waitrequest  out  1  backpressure
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  read beat valid
REQ-007 The block SHALL have one host master port h_*, with the same signals and directions mirrored, driving the shared host-memory path.
REQ-008 The block SHALL have err_unexp_rdv  out  1, a sticky error flag.

Function
REQ-009 The FSM SHALL have states IDLE and WR_BURST.
REQ-010 In IDLE, the block SHALL arbitrate among requesters (mN_read|mN_write) combinationally and forward the winner's command to h_* in the same cycle.
REQ-011 Round robin: when both masters request, the master not granted last SHALL win; the pointer SHALL update only on an accepted command (granted strobe & !h_waitrequest).
REQ-012 A non-granted master SHALL see mN_waitrequest=1; a granted master SHALL see mN_waitrequest=h_waitrequest.
REQ-013 On an accepted read, the block SHALL push {id, burstcount} into the pending FIFO; burstcount 0 SHALL be treated as 1.
REQ-014 When the pending FIFO is full, read requests SHALL be excluded from arbitration (waitrequest=1) and write requests SHALL still be served.
REQ-015 h_readdatavalid SHALL be routed to mN_readdatavalid of the FIFO-head id in the same cycle; h_readdata SHALL be broadcast to both masters.
REQ-016 A beat counter SHALL count returned beats; on the last beat of the head burst the head entry SHALL pop, and the next beat SHALL route to the new head with no bubble.
REQ-017 A simultaneous push and pop SHALL keep the FIFO occupancy unchanged and SHALL be legal at full.
REQ-018 h_readdatavalid with an empty FIFO SHALL be dropped and SHALL set err_unexp_rdv until reset.
REQ-019 An accepted first write beat with burstcount>1 SHALL enter WR_BURST, locking the grant to that master for the remaining burstcount-1 beats; burstcount 1 SHALL stay in IDLE.
REQ-020 In WR_BURST, the block SHALL forward only the locked master, SHALL count beats on write & !h_waitrequest, and SHALL return to IDLE after the last beat.
REQ-021 Read responses SHALL continue to be routed during WR_BURST.

Reset
REQ-022 While reset is asserted, the block SHALL drive h_read=0, h_write=0, mN_waitrequest=1, mN_readdatavalid=0, err_unexp_rdv=0; the FSM SHALL be in IDLE, the FIFO empty, counters 0, and the RR pointer =1 (m0 wins first).
REQ-023 Reset mid-burst SHALL abandon all pending state with no completion of any burst.

Configuration
REQ-024 Macro AVMM_ARB_FIXED_PRIO_EN: when defined, m0 SHALL always win simultaneous requests (m1 only if m0 idle); when undefined, round robin per REQ-011 SHALL apply.

Verification
REQ-025 m0 read burst 4 @0x1000 and m1 read burst 2 @0x2000 in the same cycle -> h_* issues m0 first, then m1; 4 rdv beats go to m0, then 2 to m1, with no cross-routing.
REQ-026 m0 write burst 8 while m1 requests a read -> m1 waitrequest=1 for all 8 beats; the m1 read is issued on the cycle after the 8th beat.
REQ-027 16 single-beat reads with no responses -> the 17th read is stalled, a concurrent write is accepted, and the first rdv unblocks the read next cycle.
REQ-028 h_readdatavalid pulse with an empty FIFO -> no mN_readdatavalid, and err_unexp_rdv=1 until reset.
REQ-029 Both masters request continuously -> grants alternate m0,m1,m0; with AVMM_ARB_FIXED_PRIO_EN defined -> m0 on every grant.
REQ-030 Reset asserted on the 3rd beat of a write burst 8 -> h_write=0 immediately; after reset, the FSM is in IDLE and a new m1 write is granted.
